// File: rtl/axi4_burst_selftest_master.sv
// AXI4 burst self-test master: writes a pattern over a memory window,
// reads it back, and reports a saturating error count.
module axi4_burst_selftest_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_BURST_LEN = 16,
    parameter int C_NUM_BURSTS = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_TARGET_BASE = 'h4000_0000,
    parameter int C_PATTERN = 0
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            INIT_AXI_TXN,
    output logic                            TXN_DONE,
    output logic                            ERROR,
    output logic [15:0]                     ERR_COUNT,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]                      M_AXI_ARLEN,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RLAST,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int NREP = DW / 32;
    localparam int BURST_BYTES = C_BURST_LEN * (DW / 8);
    localparam int BW = $clog2(C_NUM_BURSTS + 1);
    localparam logic [7:0] LEN8 = 8'(C_BURST_LEN - 1);
    localparam logic [31:0] SEED = 32'hACE1_0001;
    localparam logic [31:0] TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ADDR, S_WR_DATA, S_WR_RESP,
        S_RD_ADDR, S_RD_DATA, S_DONE
    } state_t;

    state_t state_q;
    logic init_q;
    logic [BW-1:0] bcnt_q;
    logic [7:0] beat_q;
    logic [31:0] gidx_q;
    logic [31:0] lfsr_q;
    logic [15:0] err_q;
    logic awvalid_q, wvalid_q, bready_q;
    logic arvalid_q, rready_q;
    logic done_q, error_q;

    logic start;
    logic last_beat, last_burst;
    logic [31:0] lfsr_d;
    logic [DW-1:0] pat_d;
    logic [AW-1:0] addr_d;
    logic rd_bad, rlast_bad;
    logic [1:0] rerr_d;
    logic [15:0] err_rd_d;
    logic [15:0] err_b_d;

    function automatic logic [15:0] sat_add(input logic [15:0] c,
                                            input logic [1:0] n);
        logic [16:0] s;
        s = {1'b0, c} + 17'(n);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign start = INIT_AXI_TXN & ~init_q;
    assign last_beat = (beat_q == LEN8);
    assign last_burst = (bcnt_q == BW'(C_NUM_BURSTS - 1));
    assign addr_d = C_TARGET_BASE + (AW'(bcnt_q) * AW'(BURST_BYTES));
    assign pat_d = (C_PATTERN == 1) ? {NREP{lfsr_q}}
                                    : DW'(gidx_q + 32'd1);

    // Galois LFSR step, taps x^32+x^22+x^2+x+1
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[31:1]};
        if (lfsr_q[0]) lfsr_d = lfsr_d ^ TAPS;
    end

    // Data/resp miscompare is one error; a wrong RLAST is a second one
    assign rd_bad = (M_AXI_RRESP != 2'b00) || (M_AXI_RDATA != pat_d);
    assign rlast_bad = (M_AXI_RLAST != last_beat);
    assign rerr_d = 2'(rd_bad) + 2'(rlast_bad);
    assign err_rd_d = sat_add(err_q, rerr_d);
    assign err_b_d = sat_add(err_q, 2'(M_AXI_BRESP != 2'b00));

    // Pass sequencer: one burst in flight, valids raised a cycle after entry
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q   <= S_IDLE;
            init_q    <= 1'b0;
            bcnt_q    <= '0;
            beat_q    <= '0;
            gidx_q    <= '0;
            lfsr_q    <= SEED;
            err_q     <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            init_q <= INIT_AXI_TXN;
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_WR_ADDR;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                        err_q   <= '0;
                        bcnt_q  <= '0;
                        beat_q  <= '0;
                        gidx_q  <= '0;
                        lfsr_q  <= SEED;
                    end
                end
                S_WR_ADDR: begin
                    if (!awvalid_q) begin
                        awvalid_q <= 1'b1;
                    end else if (M_AXI_AWREADY) begin
                        awvalid_q <= 1'b0;
                        state_q   <= S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (!wvalid_q) begin
                        wvalid_q <= 1'b1;
                    end else if (M_AXI_WREADY) begin
                        gidx_q <= gidx_q + 32'd1;
                        lfsr_q <= lfsr_d;
                        if (last_beat) begin
                            wvalid_q <= 1'b0;
                            beat_q   <= '0;
                            bready_q <= 1'b1;
                            state_q  <= S_WR_RESP;
                        end else begin
                            beat_q <= beat_q + 8'd1;
                        end
                    end
                end
                S_WR_RESP: begin
                    if (M_AXI_BVALID && bready_q) begin
                        bready_q <= 1'b0;
                        err_q    <= err_b_d;
                        if (last_burst) begin
                            bcnt_q  <= '0;
                            gidx_q  <= '0;
                            lfsr_q  <= SEED;
                            state_q <= S_RD_ADDR;
                        end else begin
                            bcnt_q  <= bcnt_q + BW'(1);
                            state_q <= S_WR_ADDR;
                        end
                    end
                end
                S_RD_ADDR: begin
                    if (!arvalid_q) begin
                        arvalid_q <= 1'b1;
                    end else if (M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (M_AXI_RVALID && rready_q) begin
                        err_q  <= err_rd_d;
                        gidx_q <= gidx_q + 32'd1;
                        lfsr_q <= lfsr_d;
                        if (last_beat) begin
                            rready_q <= 1'b0;
                            beat_q   <= '0;
                            if (last_burst) begin
                                done_q  <= 1'b1;
                                error_q <= (err_rd_d != 16'd0);
                                state_q <= S_DONE;
                            end else begin
                                bcnt_q  <= bcnt_q + BW'(1);
                                state_q <= S_RD_ADDR;
                            end
                        end else begin
                            beat_q <= beat_q + 8'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign TXN_DONE      = done_q;
    assign ERROR         = error_q;
    assign ERR_COUNT     = err_q;
    assign M_AXI_AWADDR  = awvalid_q ? addr_d : '0;
    assign M_AXI_AWLEN   = LEN8;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wvalid_q ? pat_d : '0;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = wvalid_q & last_beat;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = arvalid_q ? addr_d : '0;
    assign M_AXI_ARLEN   = LEN8;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule
